pixel_write_sink: RTL and testbench

Receiving end of the pixel-write interface used by the drawers (platform, ball, bricks). Each drawer emits x, y, colour and a write enable. This block accepts those writes into a small FIFO, clips off-screen pixels, computes the linear framebuffer address, and drains entries to the framebuffer write port whenever the VGA side grants access. It sits between the drawer mux and the framebuffer memory.

---
 rtl/pixel_write_sink.sv | 131 +++++++++++++
 tb/tb_pixel_write_sink.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_sink.sv
// Pixel-write sink: buffers drawer writes in a FIFO, clips off-screen pixels and
// drains {addr, colour} to the framebuffer port on grant. Define PIXEL_DEDUP_EN to drop repeats.
module pixel_write_sink #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [2:0]  colour,
  input  logic        writeEn,
  output logic        full,
  output logic        empty,
  input  logic        mem_ready,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_wren,
  output logic [7:0]  drop_count,
  output logic [7:0]  clip_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 18;

  logic [ENTRY_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [14:0]        mem_addr_reg;
  logic [2:0]         mem_data_reg;
  logic               mem_wren_reg;

  logic               in_bounds;
  logic [14:0]        push_addr;
  logic [ENTRY_W-1:0] push_entry;
  logic               dup;
  logic               push;
  logic               pop;
  logic [1:0]         sat_inc;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

  assign in_bounds  = (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
  // Truncation only matters for out-of-range coordinates, which never get stored.
  assign push_addr  = 15'(y) * 15'(SCREEN_W) + 15'(x);
  assign push_entry = {push_addr, colour};

`ifdef PIXEL_DEDUP_EN
  logic               last_valid_reg;
  logic [ENTRY_W-1:0] last_entry_reg;

  assign dup = last_valid_reg && (last_entry_reg == push_entry);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_valid_reg <= 1'b0;
      last_entry_reg <= '0;
    end else if (push) begin
      last_valid_reg <= 1'b1;
      last_entry_reg <= push_entry;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Clipping wins over everything; a duplicate is discarded without counting as a drop.
  assign push       = writeEn && in_bounds && !full && !dup;
  assign pop        = mem_ready && !empty;
  assign sat_inc[0] = writeEn && in_bounds && full && !dup;
  assign sat_inc[1] = writeEn && !in_bounds;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
      mem_wren_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_reg + PTR_W'(push);
      rd_ptr_reg   <= rd_ptr_reg + PTR_W'(pop);
      count_reg    <= count_next;
      mem_wren_reg <= pop;
      if (pop) begin
        {mem_addr_reg, mem_data_reg} <= fifo_mem[rd_ptr_reg];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sat
      logic [7:0] cnt_reg;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cnt_reg <= '0;
        end else if (sat_inc[gi] && (cnt_reg != 8'hFF)) begin
          cnt_reg <= cnt_reg + 8'd1;
        end
      end
    end
  endgenerate

  assign drop_count = g_sat[0].cnt_reg;
  assign clip_count = g_sat[1].cnt_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_data   = mem_data_reg;
  assign mem_wren   = mem_wren_reg;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Scoreboard bench for pixel_write_sink: stimulus queues expected {addr, colour},
// a negedge monitor checks every mem_wren strobe against the queue head.
module tb_pixel_write_sink;

  logic        clk;
  logic        resetn;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  logic        full;
  logic        empty;
  logic        mem_ready;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  drop_count;
  logic [7:0]  clip_count;

  logic [17:0] exp_q[$];
  int checks;
  int errors;
  int strobes;
  int s0;

  pixel_write_sink dut (
    .clk        (clk),
    .resetn     (resetn),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .writeEn    (writeEn),
    .full       (full),
    .empty      (empty),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .drop_count (drop_count),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One pixel per call, driven at the negedge so the next rising edge samples it.
  task automatic drive(input logic [9:0] px, input logic [9:0] py, input logic [2:0] pc,
                       input bit store, input logic [14:0] ea);
    @(negedge clk);
    x       = px;
    y       = py;
    colour  = pc;
    writeEn = 1'b1;
    if (store) exp_q.push_back({ea, pc});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      writeEn = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    logic [17:0] e;
    if (resetn && mem_wren) begin
      strobes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual addr=%0d data=%0d required no strobe", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("strobe_addr", int'(mem_addr), int'(e[17:3]));
        check("strobe_data", int'(mem_data), int'(e[2:0]));
        $display("strobe addr=%0d data=%0d", mem_addr, mem_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; strobes = 0;
    resetn = 1'b0; writeEn = 1'b0; mem_ready = 1'b0;
    x = '0; y = '0; colour = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_drop", drop_count, 0);
    check("rst_clip", clip_count, 0);

    // Single write, latency
    mem_ready = 1'b1;
    s0 = strobes;
    drive(10'd3, 10'd2, 3'd4, 1, 15'd323);
    @(negedge clk);
    writeEn = 1'b0;
    check("no_strobe_early", mem_wren, 0);
    @(negedge clk);
    check("strobe_latency", mem_wren, 1);
    idle(3);
    check("single_strobes", strobes - s0, 1);
    check("single_empty", empty, 1);

    // Clipping
    s0 = strobes;
    drive(10'd160, 10'd0, 3'd5, 0, 15'd0);
    drive(10'd0, 10'd120, 3'd6, 0, 15'd0);
    idle(3);
    check("clip_count", clip_count, 2);
    check("clip_empty", empty, 1);
    check("clip_strobes", strobes - s0, 0);

    // Overflow: 8 stored, 2 dropped, then back-to-back drain
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(10'(i), 10'd1, 3'(i), (i < 8), 15'(160 + i));
      if (i == 7) check("not_full_at_7", full, 0);
      if (i == 8) check("full_after_8", full, 1);
    end
    @(negedge clk);
    writeEn = 1'b0;
    check("drop_count", drop_count, 2);
    check("still_full", full, 1);
    s0 = strobes;
    mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("drain_b2b", mem_wren, 1);
    end
    @(negedge clk);
    check("drain_stop", mem_wren, 0);
    check("drain_strobes", strobes - s0, 8);
    check("drain_empty", empty, 1);

    // Simultaneous push/pop at count=3
    mem_ready = 1'b0;
    drive(10'd20, 10'd5, 3'd1, 1, 15'd820);
    drive(10'd21, 10'd5, 3'd2, 1, 15'd821);
    drive(10'd22, 10'd5, 3'd3, 1, 15'd822);
    s0 = strobes;
    drive(10'd23, 10'd5, 3'd7, 1, 15'd823);
    mem_ready = 1'b1;
    @(negedge clk);
    writeEn = 1'b0;
    check("simul_full", full, 0);
    check("simul_empty", empty, 0);
    @(negedge clk);
    @(negedge clk);
    check("simul_one_left", empty, 0);
    @(negedge clk);
    check("simul_drained", empty, 1);
    @(negedge clk);
    check("simul_strobes", strobes - s0, 4);

    // Dedup
    s0 = strobes;
    drive(10'd10, 10'd10, 3'd1, 1, 15'd1610);
    for (int k = 0; k < 3; k++) begin
`ifdef PIXEL_DEDUP_EN
      drive(10'd10, 10'd10, 3'd1, 0, 15'd1610);
`else
      drive(10'd10, 10'd10, 3'd1, 1, 15'd1610);
`endif
    end
    drive(10'd10, 10'd10, 3'd2, 1, 15'd1610);
    idle(4);
`ifdef PIXEL_DEDUP_EN
    check("dedup_strobes", strobes - s0, 2);
`else
    check("dedup_strobes", strobes - s0, 5);
`endif

    // Reset mid-drain
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(10'(30 + i), 10'd0, 3'(i), 1, 15'(30 + i));
    end
    @(negedge clk);
    writeEn = 1'b0;
    s0 = strobes;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_wren", mem_wren, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_addr", mem_addr, 0);
    check("arst_data", mem_data, 0);
    check("arst_drop", drop_count, 0);
    check("arst_clip", clip_count, 0);
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check("arst_strobes", strobes - s0, 2);
    check("arst_empty_after", empty, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
